// File: rtl/hour_edit_ctrl.sv
// rtl/hour_edit_ctrl.sv - time-programming front end for the hour-digit renderer
//
// Purpose:
//   Mirrors live RTC time (BCD hh/mm/ss) while idle. A btn_prog edge enters
//   EDIT, where left/right pick a field and up/down step it with BCD
//   wrap-around. A second btn_prog edge enters COMMIT, which raises wr_req
//   until the RTC writer acknowledges.
//   Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on up/down).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   btn_prog/left/right/up/down   debounced button levels (rising edge acts)
//   time_in1..3                   live hours/minutes/seconds, BCD
//   hour_out1..3                  displayed hours/minutes/seconds, BCD
//   program_on                    high in EDIT and COMMIT
//   cursor_pos                    selected field 0..2, bits [3:2] always 0
//   wr_req / wr_ack               commit handshake to the RTC writer

module hour_edit_ctrl #(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] time_in1,
  input  logic [7:0] time_in2,
  input  logic [7:0] time_in3,
  output logic [7:0] hour_out1,
  output logic [7:0] hour_out2,
  output logic [7:0] hour_out3,
  output logic       program_on,
  output logic [3:0] cursor_pos,
  output logic       wr_req,
  input  logic       wr_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  btn_hist_q, btn_hist_d;
  logic [7:0]  hour1_q, hour1_d;
  logic [7:0]  hour2_q, hour2_d;
  logic [7:0]  hour3_q, hour3_d;
  logic [1:0]  cursor_q, cursor_d;
  logic        program_on_q, program_on_d;
  logic        wr_req_q, wr_req_d;

  logic [4:0]  btn_now;
  logic [4:0]  btn_edge;
  logic        prog_e, left_e, right_e, up_e, down_e;
  logic        do_step;
  logic        step_up;

  // Bit order of the history register: {prog, left, right, up, down}
  assign btn_now  = {btn_prog, btn_left, btn_right, btn_up, btn_down};
  assign btn_edge = btn_now & ~btn_hist_q;
  assign prog_e   = btn_edge[4];
  assign left_e   = btn_edge[3];
  assign right_e  = btn_edge[2];
  assign up_e     = btn_edge[1];
  assign down_e   = btn_edge[0];

  // One BCD step with wrap. Anything that is not a legal value for the
  // field (bad units nibble or out of range) is forced to 00.
  function automatic logic [7:0] bcd_step(input logic [7:0] val,
                                          input logic       is_hours,
                                          input logic       inc);
    logic [7:0] max_v;
    logic [7:0] res;
    max_v = is_hours ? 8'h23 : 8'h59;
    // With a legal units nibble, BCD ordering matches binary ordering.
    if ((val[3:0] > 4'd9) || (val > max_v)) begin
      res = 8'h00;
    end else if (inc) begin
      if (val == max_v)
        res = 8'h00;
      else if (val[3:0] == 4'd9)
        res = {val[7:4] + 4'd1, 4'd0};
      else
        res = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (val == 8'h00)
        res = max_v;
      else if (val[3:0] == 4'd0)
        res = {val[7:4] - 4'd1, 4'd9};
      else
        res = {val[7:4], val[3:0] - 4'd1};
    end
    return res;
  endfunction

`ifdef AUTO_REPEAT_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        rep_phase_q, rep_phase_d;
  logic [31:0] hold_next;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

  always_comb begin
    state_d      = state_q;
    btn_hist_d   = btn_now;
    hour1_d      = hour1_q;
    hour2_d      = hour2_q;
    hour3_d      = hour3_q;
    cursor_d     = cursor_q;
    do_step      = 1'b0;
    step_up      = 1'b0;
`ifdef AUTO_REPEAT_EN
    // Counter clears unless an up/down hold keeps it alive in EDIT.
    hold_cnt_d   = 32'd0;
    rep_phase_d  = 1'b0;
    hold_next    = hold_cnt_q + 32'd1;
`endif

    case (state_q)
      ST_IDLE: begin
        hour1_d = time_in1;
        hour2_d = time_in2;
        hour3_d = time_in3;
        if (prog_e) begin
          state_d  = ST_EDIT;
          cursor_d = 2'd0;
        end
      end

      ST_EDIT: begin
        if (prog_e) begin
          state_d = ST_COMMIT;
        end else if (left_e || right_e) begin
          // Both together cancel out; any up/down edge this cycle is dropped.
          if (left_e && !right_e)
            cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
          else if (right_e && !left_e)
            cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
        end else begin
          if (up_e ^ down_e) begin
            do_step = 1'b1;
            step_up = up_e;
          end
`ifdef AUTO_REPEAT_EN
          // Count includes the press-edge cycle: first auto-step lands
          // when REPEAT_DELAY cycles have been held, then every REPEAT_RATE.
          if (btn_up ^ btn_down) begin
            if (up_e || down_e) begin
              hold_cnt_d = 32'd1;
            end else if (!rep_phase_q) begin
              if (hold_next == REPEAT_DELAY) begin
                do_step     = 1'b1;
                step_up     = btn_up;
                hold_cnt_d  = 32'd0;
                rep_phase_d = 1'b1;
              end else begin
                hold_cnt_d  = hold_next;
              end
            end else begin
              rep_phase_d = 1'b1;
              if (hold_next == REPEAT_RATE) begin
                do_step    = 1'b1;
                step_up    = btn_up;
                hold_cnt_d = 32'd0;
              end else begin
                hold_cnt_d = hold_next;
              end
            end
          end
`endif
        end
      end

      ST_COMMIT: begin
        if (wr_req_q && wr_ack)
          state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (do_step) begin
      case (cursor_q)
        2'd0:    hour1_d = bcd_step(hour1_q, 1'b1, step_up);
        2'd1:    hour2_d = bcd_step(hour2_q, 1'b0, step_up);
        default: hour3_d = bcd_step(hour3_q, 1'b0, step_up);
      endcase
    end

    // Registered outputs track the next state so they change with it.
    program_on_d = (state_d != ST_IDLE);
    wr_req_d     = (state_d == ST_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      btn_hist_q   <= 5'd0;
      hour1_q      <= 8'h00;
      hour2_q      <= 8'h00;
      hour3_q      <= 8'h00;
      cursor_q     <= 2'd0;
      program_on_q <= 1'b0;
      wr_req_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_cnt_q   <= 32'd0;
      rep_phase_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      btn_hist_q   <= btn_hist_d;
      hour1_q      <= hour1_d;
      hour2_q      <= hour2_d;
      hour3_q      <= hour3_d;
      cursor_q     <= cursor_d;
      program_on_q <= program_on_d;
      wr_req_q     <= wr_req_d;
`ifdef AUTO_REPEAT_EN
      hold_cnt_q   <= hold_cnt_d;
      rep_phase_q  <= rep_phase_d;
`endif
    end
  end

  assign hour_out1  = hour1_q;
  assign hour_out2  = hour2_q;
  assign hour_out3  = hour3_q;
  assign program_on = program_on_q;
  assign cursor_pos = {2'b00, cursor_q};
  assign wr_req     = wr_req_q;

endmodule

// File: tb/tb_hour_edit_ctrl.sv
// tb/tb_hour_edit_ctrl.sv - directed self-checking bench for hour_edit_ctrl

module tb_hour_edit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_prog, btn_left, btn_right, btn_up, btn_down;
  logic [7:0] time_in1, time_in2, time_in3;
  logic [7:0] hour_out1, hour_out2, hour_out3;
  logic       program_on;
  logic [3:0] cursor_pos;
  logic       wr_req;
  logic       wr_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hour_edit_ctrl #(
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_prog  (btn_prog),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .time_in1  (time_in1),
    .time_in2  (time_in2),
    .time_in3  (time_in3),
    .hour_out1 (hour_out1),
    .hour_out2 (hour_out2),
    .hour_out3 (hour_out3),
    .program_on(program_on),
    .cursor_pos(cursor_pos),
    .wr_req    (wr_req),
    .wr_ack    (wr_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mask order: {prog, left, right, up, down}; one cycle pressed, one released
  task automatic press(input logic [4:0] mask);
    {btn_prog, btn_left, btn_right, btn_up, btn_down} = mask;
    tick();
    {btn_prog, btn_left, btn_right, btn_up, btn_down} = 5'b00000;
    tick();
  endtask

  localparam logic [4:0] B_PROG  = 5'b10000;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  initial begin
    reset = 1'b1;
    {btn_prog, btn_left, btn_right, btn_up, btn_down} = 5'b00000;
    wr_ack   = 1'b0;
    time_in1 = 8'h12;
    time_in2 = 8'h34;
    time_in3 = 8'h56;
    tick();
    tick();
    chk("rst_h1", hour_out1, 8'h00);
    chk("rst_h2", hour_out2, 8'h00);
    chk("rst_h3", hour_out3, 8'h00);
    chk("rst_prog", 8'(program_on), 8'h00);
    chk("rst_cursor", 8'(cursor_pos), 8'h00);
    chk("rst_wr_req", 8'(wr_req), 8'h00);

    // Idle mirroring
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_h1", hour_out1, 8'h12);
    chk("idle_h2", hour_out2, 8'h34);
    chk("idle_h3", hour_out3, 8'h56);
    chk("idle_prog", 8'(program_on), 8'h00);
    chk("idle_cursor", 8'(cursor_pos), 8'h00);
    chk("idle_wr_req", 8'(wr_req), 8'h00);
    time_in2 = 8'h09;
    time_in3 = 8'h00;
    tick();
    chk("idle_latency_h2", hour_out2, 8'h09);

    // Enter EDIT; live time changes must be ignored
    press(B_PROG);
    chk("edit_prog", 8'(program_on), 8'h01);
    chk("edit_cursor0", 8'(cursor_pos), 8'h00);
    time_in1 = 8'h01;
    time_in2 = 8'h02;
    time_in3 = 8'h03;
    repeat (12) press(B_UP);
    chk("hours_up12_wrap", hour_out1, 8'h00);
    chk("edit_frozen_h2", hour_out2, 8'h09);
    chk("edit_frozen_h3", hour_out3, 8'h00);
    press(B_DOWN);
    chk("hours_down_wrap", hour_out1, 8'h23);

    // Cursor wrap and seconds borrow wrap
    press(B_LEFT);
    chk("cursor_left_wrap", 8'(cursor_pos), 8'h02);
    press(B_DOWN);
    chk("sec_down_wrap", hour_out3, 8'h59);
    press(B_RIGHT);
    chk("cursor_right_wrap", 8'(cursor_pos), 8'h00);
    press(B_RIGHT);
    chk("cursor_right", 8'(cursor_pos), 8'h01);
    press(B_UP);
    chk("min_carry_up", hour_out2, 8'h10);
    press(B_DOWN);
    chk("min_borrow_down", hour_out2, 8'h09);

    // Simultaneous presses and priority
    press(B_LEFT | B_RIGHT);
    chk("left_right_cancel", 8'(cursor_pos), 8'h01);
    press(B_UP | B_DOWN);
    chk("up_down_cancel", hour_out2, 8'h09);
    press(B_LEFT | B_UP);
    chk("prio_cursor", 8'(cursor_pos), 8'h00);
    chk("prio_field_dropped", hour_out2, 8'h09);
    chk("prio_h1_kept", hour_out1, 8'h23);

    // COMMIT: wr_req one cycle after the prog edge, held without ack
    btn_prog = 1'b1;
    tick();
    btn_prog = 1'b0;
    chk("commit_wr_req", 8'(wr_req), 8'h01);
    chk("commit_prog", 8'(program_on), 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("commit_hold_wr_req", 8'(wr_req), 8'h01);
    end
    press(B_UP);
    press(B_LEFT);
    press(B_PROG);
    chk("commit_ign_h1", hour_out1, 8'h23);
    chk("commit_ign_h2", hour_out2, 8'h09);
    chk("commit_ign_h3", hour_out3, 8'h59);
    chk("commit_ign_cursor", 8'(cursor_pos), 8'h00);
    chk("commit_ign_wr_req", 8'(wr_req), 8'h01);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("ack_wr_req", 8'(wr_req), 8'h00);
    chk("ack_prog", 8'(program_on), 8'h00);
    tick();
    chk("back_idle_h1", hour_out1, 8'h01);

    // Invalid BCD in selected field clears it
    time_in3 = 8'h7A;
    tick();
    press(B_PROG);
    chk("snap_invalid_h3", hour_out3, 8'h7A);
    press(B_LEFT);
    press(B_UP);
    chk("invalid_up_zero", hour_out3, 8'h00);

    // Reset in the middle of COMMIT
    press(B_PROG);
    chk("commit2_wr_req", 8'(wr_req), 8'h01);
    reset = 1'b1;
    tick();
    chk("rst_commit_wr_req", 8'(wr_req), 8'h00);
    chk("rst_commit_prog", 8'(program_on), 8'h00);
    chk("rst_commit_cursor", 8'(cursor_pos), 8'h00);
    chk("rst_commit_h1", hour_out1, 8'h00);
    reset = 1'b0;

`ifdef AUTO_REPEAT_EN
    // Held up for 10 cycles: edge step plus steps at held counts 4,6,8,10
    time_in1 = 8'h12;
    tick();
    tick();
    press(B_PROG);
    btn_up = 1'b1;
    repeat (10) tick();
    btn_up = 1'b0;
    tick();
    chk("auto_repeat_h1", hour_out1, 8'h17);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
